pipelined_tiled_mul: RTL and testbench
======================================

// Module: pipelined_tiled_mul
// PURPOSE
//  Parametrised, pipelined wide multiplier; successor to the combinational 32x32->64 mapping target.
//  Splits operands into DSP-sized tiles (TILE_A x TILE_B), registers the partial products, then sums them.
//  Intended as a Churchroad integration target for multi-DSP mapping on xilinx-ultrascale-plus.
//  Adds per-transaction signed/unsigned mode, a valid/ready handshake with backpressure, and a tag passthrough.
// PARAMETERS
//  A_WIDTH    32  operand a width (>=2)
//  B_WIDTH    32  operand b width (>=2)
//  OUT_WIDTH  64  result width; product truncated to low OUT_WIDTH bits (<= A_WIDTH+B_WIDTH)
//  TILE_A     17  a-slice width per partial product (<=26, fits DSP48E2 27-bit signed port)
//  TILE_B     17  b-slice width per partial product (<=17, fits DSP48E2 18-bit signed port)
//  TAG_WIDTH  4   width of user tag carried alongside each operation
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operands/mode/tag valid
//  in_ready   out  1          block accepts input this cycle
//  in_signed  in   1          1: a,b two's complement; 0: unsigned
//  in_tag     in   TAG_WIDTH  user tag, returned with result
//  a          in   A_WIDTH    multiplicand
//  b          in   B_WIDTH    multiplier
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  out_tag    out  TAG_WIDTH  tag of the transaction in out
//  out        out  OUT_WIDTH  product
// BEHAVIOUR
//  - Reset: clk and rst only, synchronous active-high. All stage valids clear; out_valid=0, out=0, out_tag=0.
//    in_ready=1 in the first cycle after reset.
//  - Reset mid-operation discards all in-flight transactions. No result from before reset is ever presented.
//  - Transfer: input fires when in_valid&&in_ready. Output fires when out_valid&&out_ready.
//  - Pipeline, 3 register stages, latency exactly 3 cycles when unstalled:
//    - S1: register a, b, in_signed, in_tag.
//    - S2: register every tile partial product, with sign handling applied per tile.
//    - S3: register the summed, truncated result. S3 drives out/out_tag/out_valid.
//  - Stall: stall = out_valid && !out_ready. On stall every stage holds its contents, and in_ready = !stall.
//    Bubbles are not squeezed out while stalled.
//  - Throughput: one result per cycle when out_ready stays 1.
//  - out and out_tag stay stable while out_valid && !out_ready.
//  - Arithmetic:
//    - Unsigned: out = (a*b)[OUT_WIDTH-1:0].
//    - Signed: out = ($signed(a)*$signed(b))[OUT_WIDTH-1:0].
//    - Tiling: a is split into ceil(A_WIDTH/TILE_A) slices and b into ceil(B_WIDTH/TILE_B) slices.
//      Lower slices are zero-extended. In signed mode the top slice is sign-extended.
//    - Partial products are shifted by their slice offsets and summed modulo 2^OUT_WIDTH.
//  - in_signed is sampled with the operands and travels with the transaction. Mixed-mode back-to-back ops are legal.
//  - While stage valid bits are 0 the data registers may hold stale values. out must be ignored when out_valid=0.
//  - No combinational path from in_* to out_*. in_ready depends only on out_valid and out_ready.
//  - Synthesis: each partial-product multiply infers a single DSP48E2 without carry cascade across tiles.
//  - Assertions: static check that TILE_A<=26, TILE_B<=17 and OUT_WIDTH<=A_WIDTH+B_WIDTH.
// TESTING
//  T1 unsigned: a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, tag=3, out_ready=1
//     -> 3 cycles later out=64'hFFFF_FFFE_0000_0001, out_tag=3.
//  T2 signed: a=32'hFFFF_FFFF, b=32'h0000_0005 -> out=64'hFFFF_FFFF_FFFF_FFFB.
//     Same operands unsigned on the next cycle -> out=64'h0000_0004_FFFF_FFFB.
//  T3 signed corner: a=b=32'h8000_0000 -> out=64'h4000_0000_0000_0000. Unsigned -> same value.
//  T4 backpressure: stream 6 ops (tags 0..5) with out_ready low on cycles 4-7
//     -> in_ready low during stall, out held stable, all 6 results in order, none lost or duplicated.
//  T5 reset: assert rst for 1 cycle while 3 ops are in flight
//     -> out_valid=0 next cycle, no old tags ever emitted, new op after reset has latency 3.
//  T6 random: 10k random a/b/mode/tag with random out_ready against a $signed/unsigned reference model,
//     also with parameters A_WIDTH=24, B_WIDTH=40, OUT_WIDTH=48.

Source files
------------

// File: rtl/pipelined_tiled_mul.sv
// Three-stage tiled multiplier: operand register, per-tile DSP partial products, summed result.
// A valid/ready handshake freezes the whole pipeline while the output is held.
module pipelined_tiled_mul #(
  parameter int A_WIDTH   = 32,
  parameter int B_WIDTH   = 32,
  parameter int OUT_WIDTH = 64,
  parameter int TILE_A    = 17,
  parameter int TILE_B    = 17,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [TAG_WIDTH-1:0] in_tag,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [OUT_WIDTH-1:0] out
);

  localparam int NA  = (A_WIDTH + TILE_A - 1) / TILE_A;
  localparam int NB  = (B_WIDTH + TILE_B - 1) / TILE_B;
  localparam int NP  = NA * NB;
  localparam int AP  = NA * TILE_A;
  localparam int BP  = NB * TILE_B;
  localparam int PPW = TILE_A + TILE_B + 2;
  localparam int XW  = (PPW > OUT_WIDTH) ? PPW : OUT_WIDTH;

  if (TILE_A > 26 || TILE_B > 17 || OUT_WIDTH > A_WIDTH + B_WIDTH ||
      A_WIDTH < 2 || B_WIDTH < 2) begin : g_bad_params
    $error("pipelined_tiled_mul: illegal parameter combination");
  end

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage 1: operands
  logic                 s1_valid_reg;
  logic                 s1_signed_reg;
  logic [TAG_WIDTH-1:0] s1_tag_reg;
  logic [A_WIDTH-1:0]   s1_a_reg;
  logic [B_WIDTH-1:0]   s1_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (!stall) begin
      s1_valid_reg <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_signed_reg <= in_signed;
      s1_tag_reg    <= in_tag;
      s1_a_reg      <= a;
      s1_b_reg      <= b;
    end
  end

  // Pad operands to whole tiles; the padding carries the sign in signed mode.
  logic [AP-1:0] a_pad;
  logic [BP-1:0] b_pad;
  always_comb begin
    a_pad = {AP{s1_signed_reg & s1_a_reg[A_WIDTH-1]}};
    b_pad = {BP{s1_signed_reg & s1_b_reg[B_WIDTH-1]}};
    a_pad[A_WIDTH-1:0] = s1_a_reg;
    b_pad[B_WIDTH-1:0] = s1_b_reg;
  end

  // Stage 2: partial products
  logic                  s2_valid_reg;
  logic [TAG_WIDTH-1:0]  s2_tag_reg;
  logic signed [PPW-1:0] pp_next [NP];
  logic signed [PPW-1:0] s2_pp_reg [NP];
  logic [OUT_WIDTH-1:0]  term [NP];

  for (genvar gi = 0; gi < NP; gi++) begin : g_pp
    localparam int IA  = gi / NB;
    localparam int IB  = gi % NB;
    localparam int OFF = IA * TILE_A + IB * TILE_B;
    logic signed [TILE_A:0] sa;
    logic signed [TILE_B:0] sb;
    logic signed [XW-1:0]   pp_x;
    logic [XW-1:0]          pp_sh;
    // Only the top slice may be negative; lower slices get a zero extension bit.
    assign sa = {(IA == NA - 1) ? a_pad[AP-1] : 1'b0, a_pad[IA*TILE_A +: TILE_A]};
    assign sb = {(IB == NB - 1) ? b_pad[BP-1] : 1'b0, b_pad[IB*TILE_B +: TILE_B]};
    assign pp_next[gi] = sa * sb;
    assign pp_x  = s2_pp_reg[gi];
    assign pp_sh = pp_x << OFF;
    assign term[gi] = pp_sh[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
    end else if (!stall) begin
      s2_valid_reg <= s1_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s2_tag_reg <= s1_tag_reg;
      for (int k = 0; k < NP; k++) begin
        s2_pp_reg[k] <= pp_next[k];
      end
    end
  end

  // Stage 3: sum modulo 2^OUT_WIDTH
  logic [OUT_WIDTH-1:0] sum_next;
  always_comb begin
    sum_next = '0;
    for (int k = 0; k < NP; k++) begin
      sum_next = sum_next + term[k];
    end
  end

  logic                 out_valid_reg;
  logic [TAG_WIDTH-1:0] out_tag_reg;
  logic [OUT_WIDTH-1:0] out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_tag_reg   <= '0;
      out_reg       <= '0;
    end else if (!stall) begin
      out_valid_reg <= s2_valid_reg;
      out_tag_reg   <= s2_tag_reg;
      out_reg       <= sum_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_tag   = out_tag_reg;
  assign out       = out_reg;

endmodule

// File: tb/tb_pipelined_tiled_mul.sv
// Bench for pipelined_tiled_mul: directed vectors, backpressure, reset and random traffic
// on a 32x32->64 instance and a 24x40->48 instance, checked against an arithmetic model.
module tb_pipelined_tiled_mul;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv0, ir0, sg0, ov0, or0;
  logic [3:0]  tg0, ot0;
  logic [31:0] a0, b0;
  logic [63:0] o0;

  logic        iv1, ir1, sg1, ov1, or1;
  logic [3:0]  tg1, ot1;
  logic [23:0] a1;
  logic [39:0] b1;
  logic [47:0] o1;

  pipelined_tiled_mul dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_signed(sg0), .in_tag(tg0),
    .a(a0), .b(b0), .out_valid(ov0), .out_ready(or0), .out_tag(ot0), .out(o0)
  );

  pipelined_tiled_mul #(.A_WIDTH(24), .B_WIDTH(40), .OUT_WIDTH(48)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_signed(sg1), .in_tag(tg1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .out_tag(ot1), .out(o1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: extend to 128 bits by mode, multiply, keep the low ow bits.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input bit sgn, input int aw, input int bw,
                                           input int ow);
    logic [127:0] ax, bx, p;
    for (int i = 0; i < 128; i++) begin
      ax[i] = (i < aw) ? a[i] : (sgn & a[aw-1]);
      bx[i] = (i < bw) ? b[i] : (sgn & b[bw-1]);
    end
    p = ax * bx;
    return p & ((128'd1 << ow) - 128'd1);
  endfunction

  typedef struct {
    logic [127:0] res;
    logic [3:0]   tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit          stl0 = 0, stl1 = 0;
  logic [63:0] h0;
  logic [47:0] h1;
  logic [3:0]  ht0, ht1;
  int          pushes0 = 0, pops0 = 0;

  // One clock: observe both DUTs at the negedge, then return 1ns after the posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      stl0 = 0;
      stl1 = 0;
    end else begin
      chk(ir0 == !(ov0 && !or0), "in_ready0", 128'(ir0), 128'(!(ov0 && !or0)));
      chk(ir1 == !(ov1 && !or1), "in_ready1", 128'(ir1), 128'(!(ov1 && !or1)));
      if (stl0)
        chk(ov0 && o0 == h0 && ot0 == ht0, "hold0", {ov0, ot0, o0}, {1'b1, ht0, h0});
      if (stl1)
        chk(ov1 && o1 == h1 && ot1 == ht1, "hold1", {ov1, ot1, o1}, {1'b1, ht1, h1});
      if (ov0 && or0) begin
        chk(q0.size() != 0, "unexpected0", {ot0, o0}, 128'(q0.size()));
        if (q0.size() != 0) begin
          e = q0.pop_front();
          pops0++;
          chk(o0 == e.res[63:0] && ot0 == e.tag, "result0", {ot0, o0}, {e.tag, e.res[63:0]});
        end
      end
      if (ov1 && or1) begin
        chk(q1.size() != 0, "unexpected1", {ot1, o1}, 128'(q1.size()));
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk(o1 == e.res[47:0] && ot1 == e.tag, "result1", {ot1, o1}, {e.tag, e.res[47:0]});
        end
      end
      if (iv0 && ir0) begin
        q0.push_back('{ref_mul(64'(a0), 64'(b0), sg0, 32, 32, 64), tg0});
        pushes0++;
      end
      if (iv1 && ir1) q1.push_back('{ref_mul(64'(a1), 64'(b1), sg1, 24, 40, 48), tg1});
      stl0 = ov0 && !or0;
      stl1 = ov1 && !or1;
      h0 = o0; ht0 = ot0;
      h1 = o1; ht1 = ot1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    logic [3:0]  tag;
    logic [63:0] exp;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    int   n, base_push, base_pop;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd3, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFB};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 4'd5, 64'h0000_0004_FFFF_FFFB};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 4'd6, 64'h4000_0000_0000_0000};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 4'd7, 64'h4000_0000_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd8, 64'h0000_0000_0000_0001};
    vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 4'd9, 64'h3FFF_FFFF_0000_0001};
    vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd10, 64'hC000_0000_8000_0000};
    vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 4'd11, 64'h3FFF_FFFF_8000_0000};

    rst = 1'b1;
    iv0 = 0; sg0 = 0; tg0 = 0; a0 = 0; b0 = 0; or0 = 1;
    iv1 = 0; sg1 = 0; tg1 = 0; a1 = 0; b1 = 0; or1 = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk(ov0 == 0 && o0 == 0 && ot0 == 0, "reset_out0", {ov0, ot0, o0}, 128'd0);
    chk(ir0 == 1, "reset_in_ready0", 128'(ir0), 128'd1);
    chk(ov1 == 0 && o1 == 0 && ot1 == 0, "reset_out1", {ov1, ot1, o1}, 128'd0);
    chk(ir1 == 1, "reset_in_ready1", 128'(ir1), 128'd1);

    // Directed vectors back to back: entry k must appear exactly 3 cycles later.
    for (int k = 0; k < 12; k++) begin
      if (k < 9) begin
        iv0 = 1; a0 = vecs[k].a; b0 = vecs[k].b; sg0 = vecs[k].sgn; tg0 = vecs[k].tag;
      end else begin
        iv0 = 0;
      end
      @(negedge clk);
      if (k >= 3)
        chk(ov0 && o0 == vecs[k-3].exp && ot0 == vecs[k-3].tag, "vector",
            {ov0, ot0, o0}, {1'b1, vecs[k-3].tag, vecs[k-3].exp});
      else
        chk(!ov0, "vector_latency", 128'(ov0), 128'd0);
      @(posedge clk);
      #1;
    end
    iv0 = 0;
    repeat (2) cycle();

    // Backpressure: 6 ops, out_ready low on cycles 4..7.
    base_push = pushes0;
    base_pop  = pops0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      iv0 = (pushes0 - base_push) < 6;
      a0  = $urandom;
      b0  = $urandom;
      sg0 = 1'($urandom);
      tg0 = 4'(pushes0 - base_push);
      or0 = !(cyc >= 4 && cyc <= 7);
      if (cyc == 6) chk(!ir0, "stall_in_ready", 128'(ir0), 128'd0);
      cycle();
    end
    chk(pops0 - base_pop == 6, "bp_count", 128'(pops0 - base_pop), 128'd6);
    chk(q0.size() == 0, "bp_drain", 128'(q0.size()), 128'd0);

    // Reset with three ops in flight.
    or0 = 1;
    for (int k = 0; k < 3; k++) begin
      iv0 = 1; a0 = $urandom; b0 = $urandom; sg0 = 0; tg0 = 4'(12 + k);
      cycle();
    end
    iv0 = 0;
    rst = 1;
    cycle();
    rst = 0;
    chk(!ov0, "reset_flush", 128'(ov0), 128'd0);
    repeat (5) cycle();
    iv0 = 1; a0 = 32'd1234; b0 = 32'd5678; sg0 = 0; tg0 = 4'd9;
    cycle();
    iv0 = 0;
    n = 1;
    while (!ov0 && n < 10) begin
      cycle();
      n++;
    end
    chk(n == 3, "reset_new_latency", 128'(n), 128'd3);
    repeat (3) cycle();

    // Random traffic on both instances.
    for (int i = 0; i < 10000; i++) begin
      iv0 = $urandom_range(0, 3) != 0;
      a0  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b0  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      sg0 = 1'($urandom);
      tg0 = 4'($urandom);
      or0 = $urandom_range(0, 3) != 0;
      iv1 = $urandom_range(0, 3) != 0;
      a1  = ($urandom_range(0, 7) == 0) ? 24'h80_0000 : 24'($urandom);
      b1  = {8'($urandom), 32'($urandom)};
      sg1 = 1'($urandom);
      tg1 = 4'($urandom);
      or1 = $urandom_range(0, 3) != 0;
      cycle();
    end
    iv0 = 0; iv1 = 0; or0 = 1; or1 = 1;
    repeat (8) cycle();
    chk(q0.size() == 0, "final_drain0", 128'(q0.size()), 128'd0);
    chk(q1.size() == 0, "final_drain1", 128'(q1.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
